// File: rtl/nrzi_encoder_if.sv
// Serial bit-stream and line-side signals of the NRZI encoder, grouped as one bus.
// The encoder takes the slave view; the bit-stuffing stage (or a bench) takes the master view.
interface nrzi_encoder_if;
    logic bstr_in;
    logic bstr_in_ready;
    logic pkt_start;
    logic pkt_end;
    logic dp;
    logic dm;
    logic tx_active;
    logic err;

    modport master (
        output bstr_in, bstr_in_ready, pkt_start, pkt_end,
        input  dp, dm, tx_active, err
    );

    modport slave (
        input  bstr_in, bstr_in_ready, pkt_start, pkt_end,
        output dp, dm, tx_active, err
    );
endinterface

// File: rtl/nrzi_encoder.sv
// NRZI line encoder with EOP generation; all outputs are registered (one cycle latency).
// Defining NRZI_SYNC_EN adds on-chip SYNC generation started by pkt_start.
module nrzi_encoder (
    input  logic          clk,
    input  logic          rst,
    nrzi_encoder_if.slave bus
);

`ifdef NRZI_SYNC_EN
    typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP1, EOP2, EOP_J} state_t;
`else
    typedef enum logic [2:0] {IDLE, DATA, EOP1, EOP2, EOP_J} state_t;
`endif

    state_t     r_state;
    state_t     w_nextState;
    logic       r_lvl;
    logic       w_nextLvl;
    logic       w_encLvl;
    logic [1:0] w_nextLine;
    logic       w_drop;
    logic       r_dp;
    logic       r_dm;
    logic       r_err;
    logic       r_txActive;

`ifdef NRZI_SYNC_EN
    logic [2:0] r_syncCnt;
`endif

    // lvl is 1 for J and 0 for K; a 0 bit toggles the line, a 1 bit holds it
    assign w_encLvl = bus.bstr_in ? r_lvl : ~r_lvl;

    always_comb begin
        w_nextState = r_state;
        w_nextLvl   = r_lvl;
        w_nextLine  = {r_lvl, ~r_lvl};
        w_drop      = 1'b0;
        case (r_state)
            IDLE: begin
                w_nextLvl  = 1'b1;
                w_nextLine = 2'b10;
`ifdef NRZI_SYNC_EN
                w_drop = bus.bstr_in_ready;
                if (bus.pkt_start) begin
                    // first SYNC bit is a 0, so the line leaves J for K right away
                    w_nextState = SYNC;
                    w_nextLvl   = 1'b0;
                    w_nextLine  = 2'b01;
                end
`else
                if (bus.bstr_in_ready) begin
                    w_nextLvl   = w_encLvl;
                    w_nextLine  = {w_encLvl, ~w_encLvl};
                    w_nextState = bus.pkt_end ? EOP1 : DATA;
                end
`endif
            end
`ifdef NRZI_SYNC_EN
            SYNC: begin
                w_drop     = bus.bstr_in_ready;
                w_nextLvl  = (r_syncCnt == 3'd7) ? r_lvl : ~r_lvl;
                w_nextLine = {w_nextLvl, ~w_nextLvl};
                if (r_syncCnt == 3'd7) begin
                    w_nextState = DATA;
                end
            end
`endif
            DATA: begin
                if (bus.bstr_in_ready) begin
                    w_nextLvl = w_encLvl;
                end
                w_nextLine = {w_nextLvl, ~w_nextLvl};
                if (bus.pkt_end) begin
                    w_nextState = EOP1;
                end
            end
            EOP1: begin
                w_drop      = bus.bstr_in_ready;
                w_nextLine  = 2'b00;
                w_nextState = EOP2;
            end
            EOP2: begin
                w_drop      = bus.bstr_in_ready;
                w_nextLine  = 2'b00;
                w_nextState = EOP_J;
            end
            EOP_J: begin
                w_drop      = bus.bstr_in_ready;
                w_nextLvl   = 1'b1;
                w_nextLine  = 2'b10;
                w_nextState = IDLE;
            end
            default: begin
                w_nextLvl   = 1'b1;
                w_nextLine  = 2'b10;
                w_nextState = IDLE;
            end
        endcase
    end

    // tx_active also covers the trailing J so it spans the whole registered line activity
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_lvl      <= 1'b1;
            r_dp       <= 1'b1;
            r_dm       <= 1'b0;
            r_err      <= 1'b0;
            r_txActive <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_lvl      <= w_nextLvl;
            r_dp       <= w_nextLine[1];
            r_dm       <= w_nextLine[0];
            r_err      <= w_drop;
            r_txActive <= (r_state != IDLE) || (w_nextState != IDLE);
        end
    end

`ifdef NRZI_SYNC_EN
    // counter starts at 1 because the first SYNC bit is emitted on the IDLE->SYNC transition
    always_ff @(posedge clk) begin
        if (rst) begin
            r_syncCnt <= 3'd0;
        end else if (r_state == IDLE && w_nextState == SYNC) begin
            r_syncCnt <= 3'd1;
        end else if (r_state == SYNC) begin
            r_syncCnt <= r_syncCnt + 3'd1;
        end
    end
`endif

    assign bus.dp        = r_dp;
    assign bus.dm        = r_dm;
    assign bus.err       = r_err;
    assign bus.tx_active = r_txActive;

endmodule

// File: tb/tb_nrzi_encoder.sv
// Randomized self-checking bench for nrzi_encoder; expected line activity is built per packet.
// Build with NRZI_SYNC_EN defined to exercise the SYNC-generating variant.
module tb_nrzi_encoder;

    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;
`ifdef NRZI_SYNC_EN
    localparam bit USE_SYNC = 1'b1;
`else
    localparam bit USE_SYNC = 1'b0;
`endif

    typedef struct {
        logic rst;
        logic ready;
        logic bitVal;
        logic endVal;
        logic startVal;
    } StimEntry;

    typedef struct {
        logic [1:0] line;
        logic       tx;
        logic       err;
    } ExpEntry;

    logic clk;
    logic rst;
    int   compareCount;
    int   mismatchCount;

    StimEntry stimQ[$];
    ExpEntry  expQ[$];

    nrzi_encoder_if bus ();

    nrzi_encoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] lineOf(input logic lvl);
        return lvl ? LINE_J : LINE_K;
    endfunction

    function automatic logic rnd();
        return logic'($urandom_range(0, 1));
    endfunction

    task automatic checkOutput(input string tag, input logic [1:0] observed, input logic [1:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
        end
    endtask

    task automatic addCycle(input logic r, input logic rdy, input logic b, input logic e, input logic s,
                            input logic [1:0] line, input logic tx, input logic er);
        StimEntry se;
        ExpEntry  ee;
        se.rst = r; se.ready = rdy; se.bitVal = b; se.endVal = e; se.startVal = s;
        ee.line = line; ee.tx = tx; ee.err = er;
        stimQ.push_back(se);
        expQ.push_back(ee);
    endtask

    task automatic addReset();
        addCycle(1'b1, rnd(), rnd(), rnd(), rnd(), LINE_J, 1'b0, 1'b0);
    endtask

    // One packet: optional SYNC, data bits with stalls, then SE0,SE0,J unless aborted, then idle gap
    task automatic addPacket(input int n, input logic [15:0] bits, input logic [31:0] stalls,
                             input bit withSync, input int syncErrAt, input logic [2:0] eopErr,
                             input bit finish, input int gap);
        logic lvl;
        lvl = 1'b1;
        if (withSync) begin
            for (int s = 0; s < 8; s++) begin
                if (s != 7) lvl = ~lvl;
                addCycle(1'b0, logic'(s == syncErrAt), rnd(), rnd(), logic'(s == 0),
                         lineOf(lvl), 1'b1, logic'(s == syncErrAt));
            end
        end
        for (int i = 0; i < n; i++) begin
            if (i > 0 || withSync) begin
                for (int st = 0; st < int'(stalls[2*i +: 2]); st++) begin
                    addCycle(1'b0, 1'b0, rnd(), 1'b0, rnd(), lineOf(lvl), 1'b1, 1'b0);
                end
            end
            if (!bits[i]) lvl = ~lvl;
            addCycle(1'b0, 1'b1, bits[i], logic'(finish && i == n - 1),
                     (i > 0 || withSync) ? rnd() : 1'b0, lineOf(lvl), 1'b1, 1'b0);
        end
        if (finish) begin
            addCycle(1'b0, eopErr[0], rnd(), rnd(), rnd(), LINE_SE0, 1'b1, eopErr[0]);
            addCycle(1'b0, eopErr[1], rnd(), rnd(), rnd(), LINE_SE0, 1'b1, eopErr[1]);
            addCycle(1'b0, eopErr[2], rnd(), rnd(), rnd(), LINE_J,   1'b1, eopErr[2]);
            for (int g = 0; g < gap; g++) begin
                addCycle(1'b0, 1'b0, rnd(), rnd(), 1'b0, LINE_J, 1'b0, 1'b0);
            end
        end
    endtask

    task automatic applyStimulus(input StimEntry se);
        rst               = se.rst;
        bus.bstr_in_ready = se.ready;
        bus.bstr_in       = se.bitVal;
        bus.pkt_end       = se.endVal;
        bus.pkt_start     = se.startVal;
    endtask

    initial begin
        StimEntry idleStim;
        int       n;
        int       syncErrAt;
        logic [2:0] eopErr;
        bit       abort;

        compareCount  = 0;
        mismatchCount = 0;
        idleStim.rst = 1'b1; idleStim.ready = 1'b0; idleStim.bitVal = 1'b0;
        idleStim.endVal = 1'b0; idleStim.startVal = 1'b0;
        applyStimulus(idleStim);

        addReset();
        addReset();

        if (!USE_SYNC) begin
            // bits 0,1,1,0 with pkt_end on the last: K,K,K,J then SE0,SE0,J
            addPacket(4, 16'h0006, 32'h0, 1'b0, -1, 3'b000, 1'b1, 2);
            // bits 1,1, two stall cycles, then 0: J,J,J,J,K
            addPacket(3, 16'h0003, 32'h0000_0020, 1'b0, -1, 3'b000, 1'b1, 1);
            // stray bit during EOP2 is dropped with a single err pulse
            addPacket(2, 16'h0001, 32'h0, 1'b0, -1, 3'b010, 1'b1, 1);
            // reset while line is K, then a single 0 with pkt_end from IDLE
            addPacket(2, 16'h0002, 32'h0, 1'b0, -1, 3'b000, 1'b0, 0);
            addReset();
            addPacket(1, 16'h0000, 32'h0, 1'b0, -1, 3'b000, 1'b1, 2);
        end else begin
            // bit in IDLE without pkt_start is dropped
            addCycle(1'b0, 1'b1, rnd(), 1'b0, 1'b0, LINE_J, 1'b0, 1'b1);
            addCycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, LINE_J, 1'b0, 1'b0);
            // SYNC K,J,K,J,K,J,K,K then bit 1 at cycle 8 holds K
            addPacket(1, 16'h0001, 32'h0, 1'b1, -1, 3'b000, 1'b1, 1);
            // bit offered at cycle 3 of SYNC is dropped
            addPacket(2, 16'h0002, 32'h0, 1'b1, 3, 3'b000, 1'b1, 1);
        end

        for (int p = 0; p < 25; p++) begin
            n         = 1 + $urandom_range(0, 11);
            syncErrAt = (USE_SYNC && $urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : -1;
            eopErr    = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            abort     = ($urandom_range(0, 5) == 0);
            addPacket(n, 16'($urandom), 32'($urandom & $urandom), USE_SYNC, syncErrAt,
                      eopErr, !abort, $urandom_range(0, 3));
            if (abort) addReset();
        end

        for (int k = 0; k < stimQ.size(); k++) begin
            applyStimulus(stimQ[k]);
            @(posedge clk);
            #1;
            checkOutput($sformatf("line[%0d]", k), {bus.dp, bus.dm}, expQ[k].line);
            checkOutput($sformatf("tx_active[%0d]", k), {1'b0, bus.tx_active}, {1'b0, expQ[k].tx});
            checkOutput($sformatf("err[%0d]", k), {1'b0, bus.err}, {1'b0, expQ[k].err});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/nrzi_encoder.md
NRZI_ENCODER -- requirements
Module: nrzi_encoder

Interface
REQ-001 The block SHALL have these ports: clk, input, 1, the single clock; all state SHALL change only on its rising edge.
REQ-002 The block SHALL have these ports: rst, input, 1, reset, synchronous and active-high.
REQ-003 The block SHALL have these ports: bstr_in, input, 1, the stuffed serial data bit from the bit-stuffing stage.
REQ-004 The block SHALL have these ports: bstr_in_ready, input, 1, qualifies bstr_in; one bit SHALL be accepted per cycle while it is high.
REQ-005 The block SHALL have these ports: pkt_start, input, 1, a 1-cycle pulse that starts SYNC generation; it SHALL be used only when NRZI_SYNC_EN is defined.
REQ-006 The block SHALL have these ports: pkt_end, input, 1, a 1-cycle pulse marking the last data bit of a packet.
REQ-007 The block SHALL have these ports: dp, dm, output, 1 each, the registered line pair: J={1,0}, K={0,1}, SE0={0,0}.
REQ-008 The block SHALL have these ports: tx_active, output, 1, high while any state other than IDLE is active.
REQ-009 The block SHALL have these ports: err, output, 1, a 1-cycle pulse raised when an input bit is dropped.

Function
REQ-010 The FSM SHALL have exactly these states: IDLE, SYNC, DATA, EOP1, EOP2, EOP_J.
REQ-011 The internal line level lvl SHALL be 1 for J and 0 for K; the NRZI rule SHALL be: an accepted 0 toggles lvl, an accepted 1 holds lvl.
REQ-012 In IDLE, dp/dm SHALL drive J and lvl SHALL be J.
REQ-013 Latency SHALL be one cycle: a bit accepted in cycle n SHALL appear on dp/dm in cycle n+1.
REQ-014 Without NRZI_SYNC_EN, IDLE with bstr_in_ready=1 SHALL go to DATA and encode that bit in the same transition.
REQ-015 In DATA with bstr_in_ready=0, the FSM SHALL hold lvl and dp/dm; this is a stall and SHALL NOT be an error.
REQ-016 In DATA, pkt_end=1 SHALL go to EOP1; if bstr_in_ready=1 in the same cycle, that bit SHALL be encoded first and be the last data bit.
REQ-017 EOP1 and EOP2 SHALL each drive SE0 for one cycle; EOP_J SHALL drive J for one cycle and then go to IDLE; lvl SHALL be reset to J on leaving EOP_J.
REQ-018 bstr_in_ready=1 in SYNC, EOP1, EOP2 or EOP_J SHALL drop the bit and pulse err in the next cycle.
REQ-019 pkt_end in IDLE, SYNC or the EOP states SHALL be ignored with no err.
REQ-020 pkt_start outside IDLE SHALL be ignored.
REQ-021 A bit and pkt_end arriving in IDLE in the same cycle (no SYNC_EN) SHALL encode the bit and then go to EOP1.

Reset
REQ-022 rst=1 at a clock edge SHALL force IDLE, lvl=J, dp=1, dm=0, tx_active=0, err=0, and clear the SYNC counter.
REQ-023 Reset mid-packet SHALL abort with no EOP; the next packet SHALL start from J.

Configuration
REQ-024 The macro NRZI_SYNC_EN SHALL control SYNC generation.
REQ-025 Defined: pkt_start in IDLE SHALL go to SYNC, which emits the SYNC bit sequence 0000_0001 through the NRZI rule over 8 cycles using a 3-bit counter; line output SHALL be K,J,K,J,K,J,K,K; then the FSM SHALL go to DATA.
REQ-026 Defined: bstr_in_ready in IDLE without a prior pkt_start SHALL be dropped with err.
REQ-027 Not defined: pkt_start SHALL be an unused input, the SYNC state and counter SHALL be absent, and upstream SHALL supply SYNC in-stream.

Verification
REQ-028 After reset, the bench SHALL send bits 0,1,1,0 on consecutive cycles, pkt_end on the last -> dp/dm K,K,K,J, then SE0,SE0,J; tx_active high for 7 cycles, then low.
REQ-029 The bench SHALL send bits 1,1 with a 2-cycle bstr_in_ready gap, then 0 -> J,J,(J,J held),K; err=0 throughout.
REQ-030 The bench SHALL assert bstr_in_ready=1 during EOP2 -> err=1 for exactly one cycle, line still SE0, no extra bit encoded.
REQ-031 The bench SHALL assert rst during DATA with lvl=K -> next cycle dp=1, dm=0, tx_active=0; a following packet's first 0 bit drives K.
REQ-032 With NRZI_SYNC_EN, the bench SHALL pulse pkt_start and then send bit 1 at cycle 8 -> K,J,K,J,K,J,K,K then K; a bit sent at cycle 3 -> err pulse.
REQ-033 The bench SHALL send 0 with pkt_end in IDLE (no SYNC_EN) -> K, SE0, SE0, J, then IDLE.
